// File: rtl/xor_unit_arbiter_if.sv
// Client-side request/response bus for the shared XOR unit.
// The arbiter takes the slave side; requesters take the master side.
interface xor_unit_arbiter_if #(
    parameter int W = 12,
    parameter int N = 4
);
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;

    modport master (
        output req_valid,
        output req_a,
        output req_b,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  req_valid,
        input  req_a,
        input  req_b,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/xor_unit_arbiter.sv
// Round-robin sharing of one fixed-latency XOR unit among N clients,
// with a tag pipe for response routing and an enable/drain FSM.
module xor_unit_arbiter #(
    parameter int W   = 12,
    parameter int N   = 4,
    parameter int LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    xor_unit_arbiter_if.slave cli,
    output logic         unit_start,
    output logic [W-1:0] unit_a,
    output logic [W-1:0] unit_b,
    input  logic [W-1:0] unit_y,
    input  logic         unit_valid,
    output logic         busy,
    output logic         err,
    output logic [15:0]  issue_cnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [PW-1:0] rr_ptr;
    logic [N-1:0]  pend;
    logic [N-1:0]  elig;
    logic          gnt_ok;
    logic [PW-1:0] gnt_id;
    logic [N-1:0]  gnt_vec;
    logic [N-1:0]  rsp_vec;

    logic [LAT-1:0]         tag_v;
    logic [LAT-1:0][PW-1:0] tag_id;
    logic                   head_v;
    logic [PW-1:0]          head_id;
    logic                   rsp_hit;

    assign head_v  = tag_v[LAT-1];
    assign head_id = tag_id[LAT-1];

    // Grants only while running with issue enabled
    assign elig = cli.req_valid & ~pend
                & {N{(state == RUN) && en}};

    always_comb begin
        gnt_ok = 1'b0;
        gnt_id = '0;
        for (int k = 0; k < N; k++) begin
            if (!gnt_ok && elig[(int'(rr_ptr) + k) % N]) begin
                gnt_ok = 1'b1;
                gnt_id = PW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    assign gnt_vec = gnt_ok ? (N'(1) << gnt_id) : '0;
    assign cli.req_ready = gnt_vec;

    assign unit_start = gnt_ok;
    assign unit_a = gnt_ok
                  ? cli.req_a[int'(gnt_id)*W +: W] : '0;
    assign unit_b = gnt_ok
                  ? cli.req_b[int'(gnt_id)*W +: W] : '0;

    // A valid without a matching tag (or vice versa) is not routed
    assign rsp_hit = unit_valid & head_v;
    assign rsp_vec = rsp_hit ? (N'(1) << head_id) : '0;
    assign cli.rsp_valid = rsp_vec;
    assign cli.rsp_data  = unit_y;

    assign busy = (state != IDLE) || (|tag_v);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = RUN;
            RUN:     if (!en) state_nx = DRAIN;
            DRAIN:   if (!(|tag_v) && !unit_valid)
                         state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            pend      <= '0;
            tag_v     <= '0;
            tag_id    <= '0;
            err       <= 1'b0;
            issue_cnt <= '0;
        end else begin
            tag_v[0]  <= gnt_ok;
            tag_id[0] <= gnt_id;
            for (int i = 1; i < LAT; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
            pend <= (pend & ~rsp_vec) | gnt_vec;
            if (gnt_ok) begin
                rr_ptr <= PW'((int'(gnt_id) + 1) % N);
                if (issue_cnt != 16'hFFFF)
                    issue_cnt <= issue_cnt + 16'd1;
            end
            if (unit_valid != head_v)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter with a 2-cycle XOR unit model.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_xor_unit_arbiter;
    localparam int W = 12;
    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic         unit_start;
    logic [W-1:0] unit_a;
    logic [W-1:0] unit_b;
    logic [W-1:0] unit_y;
    logic         unit_valid;
    logic         busy;
    logic         err;
    logic [15:0]  issue_cnt;
    logic         inj;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] la [N];
    logic [W-1:0] lb [N];

    xor_unit_arbiter_if #(.W(W), .N(N)) cli ();

    xor_unit_arbiter #(.W(W), .N(N), .LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cli        (cli),
        .unit_start (unit_start),
        .unit_a     (unit_a),
        .unit_b     (unit_b),
        .unit_y     (unit_y),
        .unit_valid (unit_valid),
        .busy       (busy),
        .err        (err),
        .issue_cnt  (issue_cnt)
    );

    // Two-cycle XOR unit model sharing rst_n
    logic         v1, v2;
    logic [W-1:0] y1, y2;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            y1 <= '0;
            y2 <= '0;
        end else begin
            v1 <= unit_start;
            y1 <= unit_a ^ unit_b;
            v2 <= v1;
            y2 <= y1;
        end
    end
    assign unit_valid = v2 | inj;
    assign unit_y     = y2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic load_lanes();
        for (int i = 0; i < N; i++) begin
            la[i] = W'(12'h111 * (i + 1));
            lb[i] = 12'hF0F;
            cli.req_a[i*W +: W] = la[i];
            cli.req_b[i*W +: W] = lb[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        inj = 1'b0;
        cli.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        cli.req_valid = 4'b1111;
        #1;
        n_tests++;
        if (cli.req_ready !== 4'b0000 || unit_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: ready=%b start=%b want 0000 0",
                     cli.req_ready, unit_start);
        end
        n_tests++;
        if (unit_a !== 12'h000 || unit_b !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_oper: a=%h b=%h want 000 000",
                     unit_a, unit_b);
        end
        n_tests++;
        if (cli.rsp_valid !== 4'b0000 || busy !== 1'b0
            || err !== 1'b0 || issue_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: rsp=%b busy=%b err=%b cnt=%0d want 0",
                     cli.rsp_valid, busy, err, issue_cnt);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        cli.req_a[0 +: W] = 12'hA5A;
        cli.req_b[0 +: W] = 12'h0F0;
        en = 1'b1;
        cli.req_valid = 4'b0001;
        #1;
        n_tests++;
        if (cli.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_idle: ready=%b want 0000", cli.req_ready);
        end
        @(negedge clk); #1;
        n_tests++;
        if (cli.req_ready !== 4'b0001 || unit_start !== 1'b1
            || unit_a !== 12'hA5A || unit_b !== 12'h0F0) begin
            n_fail++;
            $display("FAIL single_issue: ready=%b start=%b a=%h b=%h want 0001 1 a5a 0f0",
                     cli.req_ready, unit_start, unit_a, unit_b);
        end
        @(negedge clk); #1;
        n_tests++;
        if (cli.req_ready !== 4'b0000 || cli.rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_t1: ready=%b rsp=%b want 0000 0000",
                     cli.req_ready, cli.rsp_valid);
        end
        @(negedge clk); #1;
        n_tests++;
        if (cli.rsp_valid !== 4'b0001 || cli.rsp_data !== 12'hAAA
            || cli.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_rsp: rsp=%b data=%h ready=%b want 0001 aaa 0000",
                     cli.rsp_valid, cli.rsp_data, cli.req_ready);
        end
        @(negedge clk); #1;
        n_tests++;
        if (cli.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_regrant: ready=%b want 0001", cli.req_ready);
        end
        cli.req_valid = 4'b0000;
        @(negedge clk); #1;
        n_tests++;
        if (issue_cnt !== 16'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cnt: cnt=%0d err=%b want 1 0", issue_cnt, err);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        logic [N-1:0] er;
        int g;
        int r;
        do_reset();
        load_lanes();
        en = 1'b1;
        cli.req_valid = 4'b1111;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k == 8) cli.req_valid = 4'b0000;
            #1;
            g = k % N;
            eg = (k < 8) ? (4'b0001 << g) : 4'b0000;
            n_tests++;
            if (cli.req_ready !== eg
                || (k < 8 && unit_a !== la[g])) begin
                n_fail++;
                $display("FAIL rr_grant[%0d]: ready=%b a=%h want %b %h",
                         k, cli.req_ready, unit_a, eg, la[g]);
            end
            if (k >= 2) begin
                r = (k - 2) % N;
                er = 4'b0001 << r;
                n_tests++;
                if (cli.rsp_valid !== er
                    || cli.rsp_data !== (la[r] ^ lb[r])) begin
                    n_fail++;
                    $display("FAIL rr_rsp[%0d]: rsp=%b data=%h want %b %h",
                             k, cli.rsp_valid, cli.rsp_data, er, la[r] ^ lb[r]);
                end
            end
            @(negedge clk);
        end
        #1;
        n_tests++;
        if (issue_cnt !== 16'd8 || err !== 1'b0
            || cli.rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_end: cnt=%0d err=%b rsp=%b want 8 0 0000",
                     issue_cnt, err, cli.rsp_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        load_lanes();
        en = 1'b1;
        cli.req_valid = 4'b0100;
        @(negedge clk); #1;
        n_tests++;
        if (cli.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_first: ready=%b want 0100", cli.req_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (cli.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL wrap_grant: ready=%b want 0100", cli.req_ready);
        end
        @(negedge clk);
        cli.req_valid = 4'b1111;
        #1;
        n_tests++;
        if (cli.req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_ptr: ready=%b want 1000", cli.req_ready);
        end
        @(negedge clk);
        cli.req_valid = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_drain();
        do_reset();
        load_lanes();
        en = 1'b1;
        cli.req_valid = 4'b0011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        cli.req_valid = 4'b0111;
        #1;
        n_tests++;
        if (cli.req_ready !== 4'b0000 || unit_start !== 1'b0
            || cli.rsp_valid !== 4'b0001) begin
            n_fail++;
            $display("FAIL drain_c2: ready=%b start=%b rsp=%b want 0000 0 0001",
                     cli.req_ready, unit_start, cli.rsp_valid);
        end
        @(negedge clk); #1;
        n_tests++;
        if (cli.req_ready !== 4'b0000 || cli.rsp_valid !== 4'b0010
            || cli.rsp_data !== (la[1] ^ lb[1]) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_c3: ready=%b rsp=%b data=%h busy=%b want 0000 0010 %h 1",
                     cli.req_ready, cli.rsp_valid, cli.rsp_data, busy, la[1] ^ lb[1]);
        end
        @(negedge clk);
        en = 1'b1;
        #1;
        n_tests++;
        if (cli.req_ready !== 4'b0000 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_c4: ready=%b busy=%b want 0000 1",
                     cli.req_ready, busy);
        end
        @(negedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || cli.req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL drain_idle: busy=%b ready=%b want 0 0000",
                     busy, cli.req_ready);
        end
        @(negedge clk); #1;
        n_tests++;
        if (cli.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL drain_resume: ready=%b want 0100", cli.req_ready);
        end
        cli.req_valid = 4'b0000;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_err();
        do_reset();
        inj = 1'b1;
        #1;
        n_tests++;
        if (cli.rsp_valid !== 4'b0000 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_inject: rsp=%b err=%b want 0000 0",
                     cli.rsp_valid, err);
        end
        @(negedge clk);
        inj = 1'b0;
        #1;
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: err=%b want 1", err);
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (err !== 1'b1 || cli.rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL err_sticky: err=%b rsp=%b want 1 0000",
                     err, cli.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        load_lanes();
        en = 1'b1;
        cli.req_valid = 4'b0011;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (cli.req_ready !== 4'b0000 || unit_start !== 1'b0
            || unit_a !== 12'h000 || cli.rsp_valid !== 4'b0000
            || busy !== 1'b0 || err !== 1'b0 || issue_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_out: ready=%b start=%b a=%h rsp=%b busy=%b err=%b cnt=%0d want all 0",
                     cli.req_ready, unit_start, unit_a, cli.rsp_valid,
                     busy, err, issue_cnt);
        end
        en = 1'b0;
        cli.req_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (cli.rsp_valid !== 4'b0000) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_norsp: stray_rsp=%b err=%b want 0 0",
                     seen, err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        inj = 1'b0;
        cli.req_valid = '0;
        cli.req_a = '0;
        cli.req_b = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_drain();
        test_err();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
